// File: rtl/opl3_fifo_pkg.sv
// Shared constants for the OPL3 sample FIFO: register indices and field positions.
package opl3_fifo_pkg;

  // Register indices (mem_addr[4:2])
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_DATA0    = 3'd1;
  localparam logic [2:0] REG_DATA1    = 3'd2;
  localparam logic [2:0] REG_CTRL     = 3'd3;
  localparam logic [2:0] REG_OVFL_CNT = 3'd4;

  // STATUS bit positions
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_OVFL      = 1;
  localparam int ST_FULL      = 2;
  localparam int ST_IRQ       = 3;
  localparam int ST_LEVEL_LSB = 16;
  localparam int ST_LEVEL_W   = 9;

  // CTRL field positions
  localparam int CTRL_ENABLE     = 0;
  localparam int CTRL_CLEAR      = 1;
  localparam int CTRL_THRESH_LSB = 8;
  localparam int CTRL_THRESH_W   = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; head data is presented combinationally.
// A push into a full FIFO is accepted only when a pop is accepted on the same edge.
// A pop from an empty FIFO is ignored. Clear wins over push and pop.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic [$clog2(DEPTH):0]     level_next,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign rdata   = mem[rd_ptr];

  // Next occupancy, also exported so the parent can register flags aligned with level
  always_comb begin
    level_next = level;
    if (clear) begin
      level_next = '0;
    end else if (push_ok && !pop_ok) begin
      level_next = level + 1'b1;
    end else if (pop_ok && !push_ok) begin
      level_next = level - 1'b1;
    end
  end

  // Storage array; no reset needed since entries are only read below level
  always_ff @(posedge clk) begin
    if (push_ok && !clear) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap modulo DEPTH; level carries the extra bit that separates full from empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      level <= level_next;
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/opl3_sample_fifo.sv
// Sample-capture peripheral: latches CHANNELS synth channels on each rising sample_clk
// into a FIFO and exposes it to the PicoRV32 native bus through a small register window.
// Bus handshake: a request (mem_valid & sel & !mem_ready) sampled at an edge commits its
// write or pop at that edge and returns mem_ready=1 for exactly one cycle, with mem_rdata
// registered at the same edge.
module opl3_sample_fifo
  import opl3_fifo_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 16
) (
  input  logic               clk_rv,
  input  logic               rst_rv_,
  input  logic               sel,
  input  logic               mem_valid,
  input  logic [4:0]         mem_addr,
  input  logic [3:0]         mem_wstrb,
  input  logic [31:0]        mem_wdata,
  output logic               mem_ready,
  output logic [31:0]        mem_rdata,
  input  logic               sample_clk,
  input  logic signed [15:0] ch_a,
  input  logic signed [15:0] ch_b,
  input  logic signed [15:0] ch_c,
  input  logic signed [15:0] ch_d,
  output logic               irq
);

  localparam int         W       = CHANNELS * 16;
  localparam int         LW      = $clog2(DEPTH) + 1;
  localparam logic [2:0] POP_IDX = (CHANNELS == 4) ? REG_DATA1 : REG_DATA0;

  logic              sample_clk_d;
  logic              enable;
  logic [7:0]        thresh;
  logic              ovfl;
  logic [15:0]       ovfl_cnt;

  logic              req;
  logic              wr;
  logic              rd;
  logic [2:0]        idx;
  logic              ctrl_wr;
  logic              clear;
  logic              push;
  logic              pop;
  logic              drop;
  logic [63:0]       sample_all;
  logic [W-1:0]      head;
  logic [LW-1:0]     level;
  logic [LW-1:0]     level_next;
  logic              full;
  logic              empty;
  logic [8:0]        level_ext;
  logic [8:0]        level_next_ext;
  logic [7:0]        thresh_next;
  logic              irq_next;
  logic [31:0]       data0;
  logic [31:0]       data1;
  logic [31:0]       rd_val;
  logic              unused_bits;

  assign req     = mem_valid & sel & ~mem_ready;
  assign wr      = req & (|mem_wstrb);
  assign rd      = req & ~(|mem_wstrb);
  assign idx     = mem_addr[4:2];
  assign ctrl_wr = wr & (idx == REG_CTRL);
  assign clear   = ctrl_wr & mem_wdata[CTRL_CLEAR];
  assign pop     = rd & (idx == POP_IDX);
  assign push    = enable & sample_clk & ~sample_clk_d;

  // Channel a lands in the most significant half-word; c/d fall off the end when CHANNELS=2
  assign sample_all = {ch_a, ch_b, ch_c, ch_d};

  // A full FIFO drops the sample unless a pop frees a slot on the same edge
  assign drop = push & full & ~pop & ~clear;

  assign unused_bits = ^{sample_all[31:0], mem_addr[1:0], mem_wdata[31:16], mem_wdata[7:2]};

  sync_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk_rv),
    .rst_n      (rst_rv_),
    .clear      (clear),
    .push       (push),
    .pop        (pop),
    .wdata      (sample_all[63 -: W]),
    .rdata      (head),
    .level      (level),
    .level_next (level_next),
    .full       (full),
    .empty      (empty)
  );

  assign level_ext      = 9'(level);
  assign level_next_ext = 9'(level_next);
  assign thresh_next    = ctrl_wr ? mem_wdata[CTRL_THRESH_LSB +: CTRL_THRESH_W] : thresh;
  assign irq_next       = (thresh_next != 8'd0) && (level_next_ext >= {1'b0, thresh_next});

  assign data0 = head[W-1 -: 32];
  assign data1 = (CHANNELS == 4) ? head[31:0] : 32'd0;

  // Register read mux; data registers read 0 when the FIFO is empty
  always_comb begin
    rd_val = 32'd0;
    case (idx)
      REG_STATUS: begin
        rd_val[ST_NOT_EMPTY]                   = ~empty;
        rd_val[ST_OVFL]                        = ovfl;
        rd_val[ST_FULL]                        = full;
        rd_val[ST_IRQ]                         = irq;
        rd_val[ST_LEVEL_LSB +: ST_LEVEL_W]     = level_ext;
      end
      REG_DATA0:    rd_val = empty ? 32'd0 : data0;
      REG_DATA1:    rd_val = empty ? 32'd0 : data1;
      REG_CTRL: begin
        rd_val[CTRL_ENABLE]                        = enable;
        rd_val[CTRL_THRESH_LSB +: CTRL_THRESH_W]   = thresh;
      end
      REG_OVFL_CNT: rd_val = {16'd0, ovfl_cnt};
      default:      rd_val = 32'd0;
    endcase
  end

  // Bus response: one-cycle ready pulse with registered read data
  always_ff @(posedge clk_rv or negedge rst_rv_) begin
    if (!rst_rv_) begin
      mem_ready <= 1'b0;
      mem_rdata <= 32'd0;
    end else begin
      mem_ready <= req;
      mem_rdata <= rd ? rd_val : 32'd0;
    end
  end

  // Control register and sample_clk edge detector
  always_ff @(posedge clk_rv or negedge rst_rv_) begin
    if (!rst_rv_) begin
      enable       <= 1'b0;
      thresh       <= 8'd0;
      sample_clk_d <= 1'b0;
    end else begin
      sample_clk_d <= sample_clk;
      if (ctrl_wr) begin
        enable <= mem_wdata[CTRL_ENABLE];
        thresh <= mem_wdata[CTRL_THRESH_LSB +: CTRL_THRESH_W];
      end
    end
  end

  // Sticky overflow flag and saturating drop counter; clear wipes both
  always_ff @(posedge clk_rv or negedge rst_rv_) begin
    if (!rst_rv_) begin
      ovfl     <= 1'b0;
      ovfl_cnt <= 16'd0;
    end else if (clear) begin
      ovfl     <= 1'b0;
      ovfl_cnt <= 16'd0;
    end else if (drop) begin
      ovfl <= 1'b1;
      if (ovfl_cnt != 16'hFFFF) ovfl_cnt <= ovfl_cnt + 16'd1;
    end
  end

  // Level interrupt, registered from the next level so it changes together with STATUS
  always_ff @(posedge clk_rv or negedge rst_rv_) begin
    if (!rst_rv_) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_next;
    end
  end

endmodule

// File: tb/tb_opl3_sample_fifo.sv
// Directed bench for opl3_sample_fifo: a 2-channel and a 4-channel instance share the bus.
module tb_opl3_sample_fifo;

  localparam logic [2:0] R_STATUS = 3'd0;
  localparam logic [2:0] R_DATA0  = 3'd1;
  localparam logic [2:0] R_DATA1  = 3'd2;
  localparam logic [2:0] R_CTRL   = 3'd3;
  localparam logic [2:0] R_OVFL   = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel2 = 1'b0;
  logic        sel4 = 1'b0;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_addr = '0;
  logic [3:0]  mem_wstrb = '0;
  logic [31:0] mem_wdata = '0;
  logic        ready2, ready4;
  logic [31:0] rdata2, rdata4;
  logic        sclk2 = 1'b0;
  logic        sclk4 = 1'b0;
  logic [15:0] ch_a = '0, ch_b = '0, ch_c = '0, ch_d = '0;
  logic        irq2, irq4;

  int checks = 0;
  int errors = 0;

  opl3_sample_fifo #(.CHANNELS(2), .DEPTH(16)) dut2 (
    .clk_rv(clk), .rst_rv_(rst_n), .sel(sel2), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(ready2), .mem_rdata(rdata2), .sample_clk(sclk2),
    .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ch_d(ch_d), .irq(irq2)
  );

  opl3_sample_fifo #(.CHANNELS(4), .DEPTH(16)) dut4 (
    .clk_rv(clk), .rst_rv_(rst_n), .sel(sel4), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(ready4), .mem_rdata(rdata4), .sample_clk(sclk4),
    .ch_a(ch_a), .ch_b(ch_b), .ch_c(ch_c), .ch_d(ch_d), .irq(irq4)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic bus_xfer(input int dev, input logic [2:0] idx, input logic [3:0] strb,
                          input logic [31:0] wdata, output logic [31:0] rdata);
    bit got;
    got = 1'b0;
    rdata = '0;
    @(negedge clk);
    mem_valid = 1'b1;
    sel2 = (dev == 2);
    sel4 = (dev == 4);
    mem_addr = {idx, 2'b00};
    mem_wstrb = strb;
    mem_wdata = wdata;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk);
      #1;
      if ((dev == 4) ? ready4 : ready2) begin
        got = 1'b1;
        rdata = (dev == 4) ? rdata4 : rdata2;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL bus_timeout: dev %0d idx %0d got no mem_ready, required 1 within 4 cycles", dev, idx);
    end
    @(negedge clk);
    mem_valid = 1'b0;
    sel2 = 1'b0;
    sel4 = 1'b0;
    mem_wstrb = '0;
  endtask

  task automatic bus_read(input int dev, input logic [2:0] idx, output logic [31:0] data);
    bus_xfer(dev, idx, 4'b0000, 32'd0, data);
  endtask

  task automatic bus_write(input int dev, input logic [2:0] idx, input logic [31:0] data);
    logic [31:0] dummy;
    bus_xfer(dev, idx, 4'b1111, data, dummy);
  endtask

  task automatic pulse(input int dev, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d);
    @(negedge clk);
    ch_a = a; ch_b = b; ch_c = c; ch_d = d;
    if (dev == 4) sclk4 = 1'b1; else sclk2 = 1'b1;
    @(negedge clk);
    sclk4 = 1'b0;
    sclk2 = 1'b0;
  endtask

  // scenario tasks
  task automatic test_reset();
    logic [31:0] v;
    repeat (3) @(negedge clk);
    checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", ready2); end
    checks++; if (rdata2 !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", rdata2); end
    checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b, required 0", irq2); end
    rst_n = 1'b1;
    bus_read(2, R_STATUS, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_status: got %h, required 00000000", v); end
    bus_read(2, R_CTRL, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h, required 00000000", v); end
    bus_read(2, R_OVFL, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL reset_ovfl_cnt: got %h, required 00000000", v); end
  endtask

  task automatic test_capture();
    logic [31:0] v;
    logic [31:0] exp;
    bus_write(2, R_CTRL, 32'h0000_0001);
    for (int i = 0; i < 3; i++) pulse(2, 16'h1111 + 16'(i), 16'h2222 + 16'(i), 16'h0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      bus_read(2, R_DATA0, v);
      exp = 32'h1111_2222 + 32'(i) * 32'h0001_0001;
      checks++; if (v !== exp) begin errors++; $display("FAIL capture_data0[%0d]: got %h, required %h", i, v, exp); end
    end
    bus_read(2, R_STATUS, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL capture_drained_status: got %h, required 00000000", v); end
    bus_read(2, R_DATA0, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL capture_empty_pop: got %h, required 00000000", v); end
    bus_read(2, R_STATUS, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL capture_empty_pop_status: got %h, required 00000000", v); end
    pulse(2, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
    bus_read(2, R_DATA1, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL capture_data1_ch2: got %h, required 00000000", v); end
    bus_read(2, 3'd5, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL capture_idx5: got %h, required 00000000", v); end
    bus_write(2, R_STATUS, 32'hFFFF_FFFF);
    bus_read(2, R_STATUS, v);
    checks++; if (v !== 32'h0001_0001) begin errors++; $display("FAIL capture_status_one: got %h, required 00010001", v); end
    bus_read(2, R_DATA0, v);
    checks++; if (v !== 32'h5555_6666) begin errors++; $display("FAIL capture_data0_after_data1: got %h, required 55556666", v); end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    logic [31:0] exp;
    bus_write(2, R_CTRL, 32'h0000_0003);
    for (int i = 0; i < 20; i++) pulse(2, 16'h0100 + 16'(i), 16'h0200 + 16'(i), 16'h0, 16'h0);
    bus_read(2, R_STATUS, v);
    checks++; if (v !== 32'h0010_0007) begin errors++; $display("FAIL ovfl_status_full: got %h, required 00100007", v); end
    bus_read(2, R_OVFL, v);
    checks++; if (v !== 32'd4) begin errors++; $display("FAIL ovfl_count: got %h, required 00000004", v); end
    for (int i = 0; i < 16; i++) begin
      bus_read(2, R_DATA0, v);
      exp = 32'h0100_0200 + 32'(i) * 32'h0001_0001;
      checks++; if (v !== exp) begin errors++; $display("FAIL ovfl_data[%0d]: got %h, required %h", i, v, exp); end
    end
    bus_read(2, R_STATUS, v);
    checks++; if (v !== 32'h0000_0002) begin errors++; $display("FAIL ovfl_sticky: got %h, required 00000002", v); end
    pulse(2, 16'h0001, 16'h0002, 16'h0, 16'h0);
    pulse(2, 16'h0003, 16'h0004, 16'h0, 16'h0);
    bus_write(2, R_CTRL, 32'h0000_0003);
    bus_read(2, R_STATUS, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL clear_status: got %h, required 00000000", v); end
    bus_read(2, R_OVFL, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL clear_ovfl_cnt: got %h, required 00000000", v); end
    bus_read(2, R_CTRL, v);
    checks++; if (v !== 32'h0000_0001) begin errors++; $display("FAIL clear_ctrl_readback: got %h, required 00000001", v); end
  endtask

  task automatic test_full_collision();
    logic [31:0] v;
    logic [31:0] exp;
    for (int i = 0; i < 16; i++) pulse(2, 16'h0300 + 16'(i), 16'h0400 + 16'(i), 16'h0, 16'h0);
    // pop and push land on the same edge
    @(negedge clk);
    ch_a = 16'h0AAA; ch_b = 16'h0BBB;
    sclk2 = 1'b1;
    mem_valid = 1'b1; sel2 = 1'b1; mem_addr = {R_DATA0, 2'b00}; mem_wstrb = 4'b0000;
    @(posedge clk);
    #1;
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL collide_ready: got %b, required 1", ready2); end
    checks++; if (rdata2 !== 32'h0300_0400) begin errors++; $display("FAIL collide_data: got %h, required 03000400", rdata2); end
    @(negedge clk);
    mem_valid = 1'b0; sel2 = 1'b0; sclk2 = 1'b0;
    bus_read(2, R_STATUS, v);
    checks++; if (v !== 32'h0010_0005) begin errors++; $display("FAIL collide_status: got %h, required 00100005", v); end
    bus_read(2, R_OVFL, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL collide_ovfl_cnt: got %h, required 00000000", v); end
    for (int i = 1; i < 17; i++) begin
      bus_read(2, R_DATA0, v);
      exp = (i == 16) ? 32'h0AAA_0BBB : 32'h0300_0400 + 32'(i) * 32'h0001_0001;
      checks++; if (v !== exp) begin errors++; $display("FAIL collide_drain[%0d]: got %h, required %h", i, v, exp); end
    end
    bus_read(2, R_STATUS, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL collide_drained: got %h, required 00000000", v); end
  endtask

  task automatic test_irq();
    logic [31:0] v;
    bus_write(2, R_CTRL, 32'h0000_0401);
    bus_read(2, R_CTRL, v);
    checks++; if (v !== 32'h0000_0401) begin errors++; $display("FAIL irq_ctrl_readback: got %h, required 00000401", v); end
    for (int i = 0; i < 3; i++) pulse(2, 16'h4000 + 16'(i), 16'h5000 + 16'(i), 16'h0, 16'h0);
    checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL irq_level3: got %b, required 0", irq2); end
    @(negedge clk);
    ch_a = 16'h4003; ch_b = 16'h5003;
    sclk2 = 1'b1;
    checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL irq_before_push4: got %b, required 0", irq2); end
    @(posedge clk);
    #1;
    checks++; if (irq2 !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b, required 1", irq2); end
    @(negedge clk);
    sclk2 = 1'b0;
    bus_read(2, R_STATUS, v);
    checks++; if (v !== 32'h0004_0009) begin errors++; $display("FAIL irq_status: got %h, required 00040009", v); end
    bus_read(2, R_DATA0, v);
    checks++; if (v !== 32'h4000_5000) begin errors++; $display("FAIL irq_pop_data: got %h, required 40005000", v); end
    checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL irq_fall: got %b, required 0", irq2); end
    bus_read(2, R_STATUS, v);
    checks++; if (v !== 32'h0003_0001) begin errors++; $display("FAIL irq_status_after_pop: got %h, required 00030001", v); end
    bus_write(2, R_CTRL, 32'h0000_0003);
  endtask

  task automatic test_four_channel();
    logic [31:0] v;
    bus_write(4, R_CTRL, 32'h0000_0001);
    pulse(4, 16'hA1A1, 16'hB2B2, 16'hC3C3, 16'hD4D4);
    pulse(4, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    bus_read(4, R_DATA0, v);
    checks++; if (v !== 32'hA1A1_B2B2) begin errors++; $display("FAIL ch4_data0: got %h, required a1a1b2b2", v); end
    bus_read(4, R_STATUS, v);
    checks++; if (v !== 32'h0002_0001) begin errors++; $display("FAIL ch4_level_after_data0: got %h, required 00020001", v); end
    bus_read(4, R_DATA1, v);
    checks++; if (v !== 32'hC3C3_D4D4) begin errors++; $display("FAIL ch4_data1: got %h, required c3c3d4d4", v); end
    bus_read(4, R_STATUS, v);
    checks++; if (v !== 32'h0001_0001) begin errors++; $display("FAIL ch4_level_after_data1: got %h, required 00010001", v); end
    bus_read(4, R_DATA0, v);
    checks++; if (v !== 32'h1234_5678) begin errors++; $display("FAIL ch4_data0_second: got %h, required 12345678", v); end
    bus_read(4, R_DATA1, v);
    checks++; if (v !== 32'h9ABC_DEF0) begin errors++; $display("FAIL ch4_data1_second: got %h, required 9abcdef0", v); end
    bus_read(4, R_DATA1, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL ch4_empty_data1: got %h, required 00000000", v); end
    bus_read(4, R_STATUS, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL ch4_empty_status: got %h, required 00000000", v); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    bus_write(2, R_CTRL, 32'h0000_0401);
    for (int i = 0; i < 5; i++) pulse(2, 16'h6000 + 16'(i), 16'h7000 + 16'(i), 16'h0, 16'h0);
    checks++; if (irq2 !== 1'b1) begin errors++; $display("FAIL rmid_irq_before: got %b, required 1", irq2); end
    bus_read(2, R_STATUS, v);
    checks++; if (v !== 32'h0005_0009) begin errors++; $display("FAIL rmid_status_before: got %h, required 00050009", v); end
    @(negedge clk);
    mem_valid = 1'b1; sel2 = 1'b1; mem_addr = {R_DATA0, 2'b00}; mem_wstrb = 4'b0000;
    @(posedge clk);
    #1;
    checks++; if (ready2 !== 1'b1) begin errors++; $display("FAIL rmid_ready_high: got %b, required 1", ready2); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (ready2 !== 1'b0) begin errors++; $display("FAIL rmid_ready_drop: got %b, required 0", ready2); end
    @(negedge clk);
    mem_valid = 1'b0; sel2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL rmid_irq_after: got %b, required 0", irq2); end
    bus_read(2, R_STATUS, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rmid_status_after: got %h, required 00000000", v); end
    bus_read(2, R_CTRL, v);
    checks++; if (v !== 32'd0) begin errors++; $display("FAIL rmid_ctrl_after: got %h, required 00000000", v); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_capture();
    test_overflow();
    test_full_collision();
    test_irq();
    test_four_channel();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
